hamming_sc_decoder: RTL and testbench

HAMMING_SC_DECODER -- requirements
Module: hamming_sc_decoder

---
 rtl/hamming_sc_decoder.sv | 132 +++++++++++++
 tb/tb_hamming_sc_decoder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/hamming_sc_decoder.sv
// Serial (15,11) Hamming single-error-correcting decoder.
// Codeword bits arrive LSB-first: the first accepted bit is position 1 and the last is position 15.
// The 11 corrected data bits are then streamed out serially from a separate shifter.
module hamming_sc_decoder (
    input  logic       CLK_IN,
    input  logic       REST,
    input  logic       DEVICE_EN,
    input  logic       SERIAL_IN,
    input  logic       IN_VALID,
    output logic       SERIAL_OUT,
    output logic       OUT_VALID,
    output logic [3:0] SYNDROME,
    output logic       ERR_CORRECTED,
    output logic [7:0] ERR_CNT
);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    state_t      state;
    logic [3:0]  bit_cnt;
    // Position 15 is never stored; it is decoded straight from SERIAL_IN in the completing cycle.
    logic [13:0] cap_reg;
    logic [10:0] out_shift;
    logic [3:0]  out_cnt;

    logic        word_done;
    logic [14:0] full_word;
    logic [3:0]  syn;
    logic [10:0] data_raw;
    logic [10:0] data_word;

    // Codeword position carried by each data bit, in output order.
    function automatic logic [3:0] data_pos(input int unsigned j);
        logic [3:0] p;
        case (j)
            0:       p = 4'd3;
            1:       p = 4'd5;
            2:       p = 4'd6;
            3:       p = 4'd7;
            default: p = 4'(j + 5);
        endcase
        return p;
    endfunction

    // Decode the word being completed: syndrome, then correct and extract the data bits.
    always_comb begin
        word_done = DEVICE_EN && IN_VALID && (bit_cnt == 4'd14);
        full_word = {SERIAL_IN, cap_reg};
        syn       = '0;
        for (int unsigned i = 0; i < 15; i++) begin
            if (full_word[i]) begin
                syn = syn ^ 4'(i + 1);
            end
        end
        data_raw  = {full_word[14:8], full_word[6:4], full_word[2]};
        data_word = '0;
        for (int unsigned j = 0; j < 11; j++) begin
            data_word[j] = data_raw[j] ^ (syn == data_pos(j));
        end
    end

    // Receive side: capture accepted bits; disabling the device drops any partial word.
    always_ff @(posedge CLK_IN) begin
        if (!REST) begin
            bit_cnt <= '0;
            cap_reg <= '0;
        end else if (!DEVICE_EN) begin
            bit_cnt <= '0;
        end else if (IN_VALID) begin
            if (bit_cnt == 4'd14) begin
                bit_cnt <= '0;
            end else begin
                cap_reg[bit_cnt] <= SERIAL_IN;
                bit_cnt          <= bit_cnt + 4'd1;
            end
        end
    end

    // Output FSM: load status and shifter on word completion, then stream 11 bits.
    always_ff @(posedge CLK_IN) begin
        if (!REST) begin
            state         <= ST_IDLE;
            out_shift     <= '0;
            out_cnt       <= '0;
            OUT_VALID     <= 1'b0;
            SYNDROME      <= '0;
            ERR_CORRECTED <= 1'b0;
            ERR_CNT       <= '0;
        end else if (word_done) begin
            state         <= ST_SHIFT;
            out_shift     <= data_word;
            out_cnt       <= '0;
            OUT_VALID     <= 1'b1;
            SYNDROME      <= syn;
            ERR_CORRECTED <= (syn != '0);
            if ((syn != '0) && (ERR_CNT != 8'hFF)) begin
                ERR_CNT <= ERR_CNT + 8'd1;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    OUT_VALID <= 1'b0;
                    out_shift <= '0;
                end
                ST_SHIFT: begin
                    if (out_cnt == 4'd10) begin
                        state     <= ST_IDLE;
                        OUT_VALID <= 1'b0;
                        out_shift <= '0;
                        out_cnt   <= '0;
                    end else begin
                        out_shift <= out_shift >> 1;
                        out_cnt   <= out_cnt + 4'd1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    OUT_VALID <= 1'b0;
                end
            endcase
        end
    end

    // Current output bit is the shifter LSB; the shifter is cleared whenever idle.
    always_comb begin
        SERIAL_OUT = out_shift[0];
    end

endmodule

// File: tb/tb_hamming_sc_decoder.sv
// Scoreboard bench for hamming_sc_decoder: stimulus pushes expected output bits,
// a negedge monitor pops and compares whenever OUT_VALID is high.
module tb_hamming_sc_decoder;

    logic       CLK_IN = 1'b0;
    logic       REST = 1'b0;
    logic       DEVICE_EN = 1'b0;
    logic       SERIAL_IN = 1'b0;
    logic       IN_VALID = 1'b0;
    logic       SERIAL_OUT;
    logic       OUT_VALID;
    logic [3:0] SYNDROME;
    logic       ERR_CORRECTED;
    logic [7:0] ERR_CNT;

    typedef struct packed {
        logic       d;
        logic [3:0] syn;
        logic       corr;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   failed = 0;
    int   exp_cnt = 0;

    hamming_sc_decoder dut (
        .CLK_IN        (CLK_IN),
        .REST          (REST),
        .DEVICE_EN     (DEVICE_EN),
        .SERIAL_IN     (SERIAL_IN),
        .IN_VALID      (IN_VALID),
        .SERIAL_OUT    (SERIAL_OUT),
        .OUT_VALID     (OUT_VALID),
        .SYNDROME      (SYNDROME),
        .ERR_CORRECTED (ERR_CORRECTED),
        .ERR_CNT       (ERR_CNT)
    );

    always #5 CLK_IN = ~CLK_IN;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle with OUT_VALID must match the head of the scoreboard.
    always @(negedge CLK_IN) begin
        if (OUT_VALID === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_out: actual=OUT_VALID 1 expected=no pending output at %0t", $time);
            end else begin
                mon_e = sb.pop_front();
                check("serial_out", {31'd0, SERIAL_OUT}, {31'd0, mon_e.d});
                check("syndrome", {28'd0, SYNDROME}, {28'd0, mon_e.syn});
                check("err_corrected", {31'd0, ERR_CORRECTED}, {31'd0, mon_e.corr});
                check("err_cnt", {24'd0, ERR_CNT}, {24'd0, mon_e.cnt});
            end
        end
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out_valid"}, {31'd0, OUT_VALID}, 32'd0);
        check({tag, "_serial_out"}, {31'd0, SERIAL_OUT}, 32'd0);
        check({tag, "_syndrome"}, {28'd0, SYNDROME}, 32'd0);
        check({tag, "_err_corrected"}, {31'd0, ERR_CORRECTED}, 32'd0);
        check({tag, "_err_cnt"}, {24'd0, ERR_CNT}, 32'd0);
    endtask

    task automatic do_reset(input int cycles);
        REST = 1'b0;
        repeat (cycles) @(posedge CLK_IN);
        #1;
        REST = 1'b1;
        sb.delete();
        exp_cnt = 0;
        @(negedge CLK_IN);
        check_zero_outputs("reset");
    endtask

    task automatic send_bit(input logic b, input int gap);
        SERIAL_IN = b;
        IN_VALID  = 1'b1;
        @(posedge CLK_IN);
        #1;
        IN_VALID  = 1'b0;
        SERIAL_IN = 1'b0;
        repeat (gap) begin
            @(posedge CLK_IN);
            #1;
        end
    endtask

    // cw[i] is codeword position i+1; data[j] is the j-th expected output bit.
    task automatic send_word(input logic [14:0] cw, input logic [10:0] data,
                             input logic [3:0] syn, input int maxgap);
        exp_t e;
        if (syn != 4'd0 && exp_cnt < 255) exp_cnt++;
        for (int j = 0; j < 11; j++) begin
            e.d    = data[j];
            e.syn  = syn;
            e.corr = (syn != 4'd0);
            e.cnt  = 8'(exp_cnt);
            sb.push_back(e);
        end
        for (int i = 0; i < 15; i++) begin
            send_bit(cw[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge CLK_IN);
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL drain_timeout: actual=%0d bits pending expected=0", sb.size());
            sb.delete();
        end
        repeat (2) @(posedge CLK_IN);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [14:0] cw;
        DEVICE_EN = 1'b1;
        do_reset(2);

        // All-zero codeword, then single error at position 5.
        send_word(15'h0000, 11'h000, 4'd0, 0);
        send_word(15'h0010, 11'h000, 4'd5, 0);
        wait_drain();
        check("zero_word_err_cnt", {24'd0, ERR_CNT}, 32'd1);

        // All-ones, then position 1 flipped, then position 15 flipped, back-to-back.
        do_reset(1);
        send_word(15'h7FFF, 11'h7FF, 4'd0, 0);
        send_word(15'h7FFE, 11'h7FF, 4'd1, 0);
        send_word(15'h3FFF, 11'h7FF, 4'd15, 0);
        wait_drain();
        check("ones_err_cnt", {24'd0, ERR_CNT}, 32'd2);
        check("ones_syndrome", {28'd0, SYNDROME}, 32'd15);

        // Mixed data word (parity 1,2,8 set), clean and with position 9 flipped.
        send_word(15'h54E7, 11'h54D, 4'd0, 0);
        send_word(15'h55E7, 11'h54D, 4'd9, 0);
        wait_drain();

        // 7-bit fragment with gaps, then disable (with IN_VALID high) discards it.
        for (int i = 0; i < 7; i++) send_bit(1'b1, int'($urandom_range(0, 2)));
        DEVICE_EN = 1'b0;
        SERIAL_IN = 1'b1;
        IN_VALID  = 1'b1;
        repeat (3) @(posedge CLK_IN);
        #1;
        IN_VALID  = 1'b0;
        SERIAL_IN = 1'b0;
        check("disable_syndrome_hold", {28'd0, SYNDROME}, 32'd9);
        check("disable_err_cnt_hold", {24'd0, ERR_CNT}, 32'd3);
        check("disable_no_output", {31'd0, OUT_VALID}, 32'd0);
        DEVICE_EN = 1'b1;
        send_word(15'h54E7, 11'h54D, 4'd0, 3);
        wait_drain();

        // Reset during the 6th output bit aborts the burst.
        send_word(15'h54E3, 11'h54D, 4'd3, 0);
        repeat (6) @(posedge CLK_IN);
        #1;
        REST = 1'b0;
        @(posedge CLK_IN);
        #1;
        REST = 1'b1;
        sb.delete();
        exp_cnt = 0;
        @(negedge CLK_IN);
        check_zero_outputs("midburst_reset");
        send_word(15'h55E7, 11'h54D, 4'd9, 0);
        wait_drain();
        check("post_reset_err_cnt", {24'd0, ERR_CNT}, 32'd1);

        // 300 single-error words: error counter saturates.
        for (int i = 0; i < 300; i++) begin
            cw = 15'd1 << (i % 15);
            send_word(cw, 11'h000, 4'((i % 15) + 1), 0);
        end
        wait_drain();
        check("sat_err_cnt", {24'd0, ERR_CNT}, 32'd255);
        check("sat_err_corrected", {31'd0, ERR_CORRECTED}, 32'd1);
        check("sat_syndrome", {28'd0, SYNDROME}, 32'd15);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
